dl_mac_vec: RTL and testbench
=============================

# dl_mac_vec

Parametrised, pipelined, multi-lane DLFloat16 multiply-accumulate engine. It is the vector successor of the single-lane MAC. Each lane computes either a per-beat fused result a*b+d, or a running dot-product sum of a*b across a burst. It sits between the operand fetch stage and the result writeback, with valid/ready handshakes on both sides.

## Interface
- LANES, default 4: number of independent MAC lanes (1..16).
- SAT_EN, default 1: 1 saturates on overflow to ±max finite (0x7DFE/0xFDFE); 0 produces inf (0xFFFF).
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  engine accepts beat this cycle.
- mode  input  1  0 = MAC (emit every beat), 1 = ACC (accumulate burst).
- in_first  input  1  ACC: first beat of burst; seeds accumulator with d.
- in_last  input  1  ACC: last beat of burst; emits result.
- a, b, d  input  16*LANES each  DLFloat16 operands; lane i at [16i+15:16i].
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- c_out  output  16*LANES  DLFloat16 results.
- exc_flags  output  5*LANES  per lane {invalid, inexact, overflow, underflow, div_zero}.

## Operation
- Format: sign[15], exp[14:9] bias 31, mant[8:0] with hidden 1. 0x0000 is zero. 0xFFFF is inf/NaN. exp==0 is flushed to zero on input.
- Stage 1 (multiply): exponent sum minus 31; 10x10 mantissa product, normalised by 1 bit; truncation, no rounding.
  - Product flushes to 0 when ea+eb ≤ 31 and sets underflow.
  - Product saturates per SAT_EN when ea+eb > 94 and sets overflow.
  - ea+eb == 94 gives 0xFFFF.
  - An operand of 0 gives 0; an operand of 0xFFFF gives 0xFFFF and sets invalid.
- Stage 2 (add): align the smaller-exponent operand right by the exponent difference, add or subtract by sign, then renormalise with a leading-one search over 11 bits.
  - Sign follows the larger magnitude; an exact cancel gives +0 (0x0000).
  - Overflow (exp would reach 63) saturates per SAT_EN and sets overflow.
  - Result exp < 1 gives ±smallest normal (0x0201/0x8201) and sets underflow.
  - Any 0xFFFF addend gives 0xFFFF.
- Addend selection:
  - mode 0: addend is d.
  - mode 1 with first: addend is d.
  - mode 1 otherwise: addend is the lane accumulator.
- Accumulator: per lane, written with every stage-2 result while mode=1.
- Flags:
  - div_zero is always 0.
  - inexact is set when nonzero bits are discarded by the product truncation, the alignment shift or the renormalisation.
  - In ACC mode, flags are sticky (ORed) across the burst and cleared on first.
  - In MAC mode, flags are per beat.
- mode, first and last are sampled with the beat and travel with it. Changing mode mid-burst abandons the burst; the accumulator is reseeded by the next first.
- In ACC mode, a beat with both first and last is a single-beat MAC and is emitted.

## Timing
- Latency is 2 cycles from the accepted beat (in_valid & in_ready) to out_valid, when there is no backpressure. Throughput is one beat per cycle.
- Pipeline advance: en = !out_valid | out_ready. in_ready = en; it is combinational and does not depend on in_valid.
- When en=0, all stage registers, the accumulator and the flags hold. c_out and exc_flags stay stable while out_valid & !out_ready.
- out_valid rises only for mode 0 beats, or for mode 1 beats with last.
- Reset (rst_n low at a clock edge), including mid-burst:
  - out_valid=0, c_out=0, exc_flags=0.
  - Accumulators and stage-1 valid are 0.
  - in_ready is 1 from the first cycle after reset.
  - In-flight beats are discarded.
- A burst without first after reset accumulates onto 0.

## Test plan
- **MAC basic:** LANES=4, mode 0; lane0 a=0x3E00 (1.0), b=0x4000 (2.0), d=0x3E00 -> c_out lane0=0x4100 (3.0) two cycles after accept; flags 0.
- **ACC burst:** mode 1, 4 beats with a=0x3E00, b=0x3E00; d=0 on first -> single out_valid after the last beat; c_out=0x4200 (4.0); no intermediate out_valid.
- **Backpressure:** hold out_ready=0 for 5 cycles while streaming mode 0 -> in_ready drops when out_valid is set; c_out is stable; there is no loss or duplication over 20 beats (scoreboard).
- **Saturation/special:** a=b=0x7C00 with SAT_EN=1 -> 0x7DFE with overflow set. With SAT_EN=0 -> 0xFFFF. Any operand 0xFFFF -> 0xFFFF with invalid set.
- **Cancellation/underflow:** a*b=1.0, d=0xBE00 -> 0x0000. Small operands with ea+eb=20 -> product 0 and underflow set, sticky through an ACC burst until the next first.
- **Reset mid-burst:** drop rst_n on beat 2 of an ACC burst -> outputs 0 next cycle. A new burst with first afterwards yields a correct sum with no residue.

Source files
------------

// File: rtl/dl_mac_vec.sv
`default_nettype none
// ===========================================================================
// Module   : dl_mac_vec
// Brief    : Multi-lane, two-stage DLFloat16 multiply-accumulate engine.
//            Stage 1 multiplies a*b per lane. Stage 2 adds the addend
//            (d or the lane accumulator) and registers the result.
// Revision : 1.0 - initial release
// ===========================================================================
module dl_mac_vec #(
   parameter int LANES  = 4,
   parameter int SAT_EN = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 mode,
   input  logic                 in_first,
   input  logic                 in_last,
   input  logic [16*LANES-1:0]  a,
   input  logic [16*LANES-1:0]  b,
   input  logic [16*LANES-1:0]  d,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [16*LANES-1:0]  c_out,
   output logic [5*LANES-1:0]   exc_flags
);

   localparam logic [15:0] C_INF = 16'hFFFF;

   // Returns {invalid, inexact, overflow, underflow, result[15:0]}.
   function automatic logic [19:0] fp_mul(input logic [15:0] x, input logic [15:0] y);
      logic        s;
      logic [6:0]  esum;
      logic [19:0] p;
      logic [5:0]  e;
      logic [8:0]  m;
      logic        inx;
      logic [15:0] sat;
      s    = x[15] ^ y[15];
      esum = {1'b0, x[14:9]} + {1'b0, y[14:9]};
      p    = 20'({1'b1, x[8:0]}) * 20'({1'b1, y[8:0]});
      // A product of two [1,2) mantissas lies in [1,4): at most one shift.
      if (p[19]) begin
         m   = p[18:10];
         inx = |p[9:0];
      end else begin
         m   = p[17:9];
         inx = |p[8:0];
      end
      e   = 6'(esum - 7'd31) + {5'd0, p[19]};
      sat = (SAT_EN != 0) ? {s, 15'h7DFE} : C_INF;
      if (x == C_INF || y == C_INF)          fp_mul = {4'b1000, C_INF};
      else if (x[14:9] == 6'd0 || y[14:9] == 6'd0) fp_mul = {4'b0000, 16'h0000};
      else if (esum <= 7'd31)                fp_mul = {4'b0001, 16'h0000};
      else if (esum > 7'd94)                 fp_mul = {4'b0010, sat};
      else if (esum == 7'd94)                fp_mul = {4'b0000, C_INF};
      else if (e == 6'd63)                   fp_mul = {4'b0010, sat};
      else                                   fp_mul = {1'b0, inx, 2'b00, s, e, m};
   endfunction

   // Returns {invalid, inexact, overflow, underflow, result[15:0]}.
   function automatic logic [19:0] fp_add(input logic [15:0] x, input logic [15:0] y);
      logic [15:0] lg, sm, sat;
      logic [5:0]  dif;
      logic [9:0]  ms, msa;
      logic [10:0] s;
      logic [3:0]  lz;
      logic [7:0]  er;
      logic [8:0]  m;
      logic        inx;
      // Larger magnitude drives the result sign and exponent.
      if (y[14:0] > x[14:0]) begin
         lg = y;
         sm = x;
      end else begin
         lg = x;
         sm = y;
      end
      dif = lg[14:9] - sm[14:9];
      ms  = {1'b1, sm[8:0]};
      msa = ms >> dif;
      inx = ((msa << dif) != ms);
      if (lg[15] == sm[15]) s = {2'b01, lg[8:0]} + {1'b0, msa};
      else                  s = {2'b01, lg[8:0]} - {1'b0, msa};
      lz = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (s[i]) lz = 4'(9 - i);
      end
      er  = s[10] ? ({2'b00, lg[14:9]} + 8'd1) : ({2'b00, lg[14:9]} - {4'd0, lz});
      m   = s[10] ? s[9:1] : 9'(s[9:0] << lz);
      inx = inx | (s[10] & s[0]);
      sat = (SAT_EN != 0) ? {lg[15], 15'h7DFE} : C_INF;
      if (x == C_INF || y == C_INF)             fp_add = {4'b0000, C_INF};
      else if (x[14:9] == 6'd0 && y[14:9] == 6'd0) fp_add = {4'b0000, 16'h0000};
      else if (x[14:9] == 6'd0)                 fp_add = {4'b0000, y};
      else if (y[14:9] == 6'd0)                 fp_add = {4'b0000, x};
      else if (s == 11'd0)                      fp_add = {1'b0, inx, 2'b00, 16'h0000};
      else if (!er[7] && er >= 8'd63)           fp_add = {1'b0, inx, 2'b10, sat};
      else if (er[7] || er == 8'd0)             fp_add = {1'b0, inx, 2'b01, lg[15], 6'd1, 9'd1};
      else                                      fp_add = {1'b0, inx, 2'b00, lg[15], er[5:0], m};
   endfunction

   logic en;
   logic s1_valid_q, s1_mode_q, s1_first_q, s1_last_q;
   logic out_valid_q;
   logic emit_d;

   assign en        = !out_valid_q || out_ready;
   assign in_ready  = en;
   assign out_valid = out_valid_q;
   assign emit_d    = s1_valid_q && (!s1_mode_q || s1_last_q);

   // Stage-1 control: beat valid plus the mode/first/last tags that travel with it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_mode_q  <= 1'b0;
         s1_first_q <= 1'b0;
         s1_last_q  <= 1'b0;
      end else if (en) begin
         s1_valid_q <= in_valid;
         s1_mode_q  <= mode;
         s1_first_q <= in_first;
         s1_last_q  <= in_last;
      end
   end

   // Output valid: only MAC beats and the last beat of an ACC burst are emitted
   always_ff @(posedge clk) begin
      if (!rst_n)  out_valid_q <= 1'b0;
      else if (en) out_valid_q <= emit_d;
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [15:0] prod_q, d_q, acc_q, acc_d, c_q, c_d, addend;
      logic [3:0]  pflg_q, aflg_q, aflg_d, flg_q, flg_d, beat_flg;
      logic [19:0] mul_w, sum_w;

      assign mul_w = fp_mul(a[16*i +: 16], b[16*i +: 16]);

      // Stage-1 data: product, its flags and the d operand of this beat
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            prod_q <= 16'h0000;
            pflg_q <= 4'h0;
            d_q    <= 16'h0000;
         end else if (en) begin
            prod_q <= mul_w[15:0];
            pflg_q <= mul_w[19:16];
            d_q    <= d[16*i +: 16];
         end
      end

      // Stage-2: addend select, add, sticky-flag merge and register next-state
      always_comb begin
         addend   = (!s1_mode_q || s1_first_q) ? d_q : acc_q;
         sum_w    = fp_add(prod_q, addend);
         beat_flg = pflg_q | sum_w[19:16];
         if (s1_mode_q && !s1_first_q) beat_flg = beat_flg | aflg_q;
         acc_d  = acc_q;
         aflg_d = aflg_q;
         c_d    = c_q;
         flg_d  = flg_q;
         if (en && s1_valid_q) begin
            if (s1_mode_q) begin
               acc_d  = sum_w[15:0];
               aflg_d = beat_flg;
            end
            if (emit_d) begin
               c_d   = sum_w[15:0];
               flg_d = beat_flg;
            end
         end
      end

      // Stage-2 state: accumulator, sticky flags and the held output
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            acc_q  <= 16'h0000;
            aflg_q <= 4'h0;
            c_q    <= 16'h0000;
            flg_q  <= 4'h0;
         end else begin
            acc_q  <= acc_d;
            aflg_q <= aflg_d;
            c_q    <= c_d;
            flg_q  <= flg_d;
         end
      end

      assign c_out[16*i +: 16]    = c_q;
      assign exc_flags[5*i +: 5]  = {flg_q, 1'b0};
   end

endmodule
`default_nettype wire

// File: tb/tb_dl_mac_vec.sv
`default_nettype none
// ===========================================================================
// Module   : tb_dl_mac_vec
// Brief    : Directed self-checking bench for dl_mac_vec (LANES=4), with one
//            saturating and one non-saturating instance on shared inputs.
// Revision : 1.0 - initial release
// ===========================================================================
module tb_dl_mac_vec;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0, mode = 1'b0, in_first = 1'b0, in_last = 1'b0;
   logic        out_ready = 1'b1;
   logic [63:0] a = '0, b = '0, d = '0;
   logic        in_ready, out_valid, in_ready0, out_valid0;
   logic [63:0] c_out, c_out0;
   logic [19:0] exc, exc0;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          k, got;
   logic [15:0] v, e;
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   dl_mac_vec #(.LANES(4), .SAT_EN(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .in_first(in_first), .in_last(in_last),
      .a(a), .b(b), .d(d), .out_valid(out_valid), .out_ready(out_ready),
      .c_out(c_out), .exc_flags(exc));

   dl_mac_vec #(.LANES(4), .SAT_EN(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
      .mode(mode), .in_first(in_first), .in_last(in_last),
      .a(a), .b(b), .d(d), .out_valid(out_valid0), .out_ready(out_ready),
      .c_out(c_out0), .exc_flags(exc0));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic m, input logic f, input logic l,
                       input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vd);
      in_valid = 1'b1; mode = m; in_first = f; in_last = l;
      a = va; b = vb; d = vd;
   endtask

   task automatic idle();
      in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- reset state ----------------
      tick(); tick();
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_cout", c_out, 64'd0);
      chk("rst_flags", 64'(exc), 64'd0);
      rst_n = 1'b1;
      tick();
      chk("rst_inready", 64'(in_ready), 64'd1);

      // ---------------- MAC stream, three vectors back to back ----------------
      beat(0, 0, 0, {16'hFFFF, 16'h7C00, 16'h3E00, 16'h3E00},
                    {16'h3E00, 16'h7C00, 16'h3E00, 16'h4000},
                    {16'h3E00, 16'h0000, 16'hBE00, 16'h3E00});
      tick();
      chk("mac_lat1_valid", 64'(out_valid), 64'd0);
      beat(0, 0, 0, {16'h3E00, 16'hC000, 16'h1400, 16'h3E01},
                    {16'h3E00, 16'h4000, 16'h1400, 16'h3E01},
                    {16'h3C01, 16'h3E00, 16'h3E00, 16'h0000});
      tick();
      chk("mac1_valid", 64'(out_valid), 64'd1);
      chk("mac1_cout", c_out, {16'hFFFF, 16'h7DFE, 16'h0000, 16'h4100});
      chk("mac1_cout_nosat", c_out0, {16'hFFFF, 16'hFFFF, 16'h0000, 16'h4100});
      chk("mac1_flags", 64'(exc), 64'({5'b10000, 5'b00100, 5'b00000, 5'b00000}));
      beat(0, 0, 0, {16'h7C00, 16'h3E00, 16'h7C00, 16'h0400},
                    {16'h4200, 16'h3E00, 16'h3E00, 16'h3E00},
                    {16'h0000, 16'hC000, 16'h7C00, 16'h8401});
      tick();
      chk("mac2_valid", 64'(out_valid), 64'd1);
      chk("mac2_cout", c_out, {16'h3F00, 16'hC100, 16'h3E00, 16'h3E02});
      chk("mac2_flags", 64'(exc), 64'({5'b01000, 5'b00000, 5'b00010, 5'b01000}));
      idle();
      tick();
      chk("mac3_valid", 64'(out_valid), 64'd1);
      chk("mac3_cout", c_out, {16'h7DFE, 16'hBE00, 16'h7DFE, 16'h8201});
      chk("mac3_cout_nosat", c_out0, {16'hFFFF, 16'hBE00, 16'hFFFF, 16'h8201});
      chk("mac3_flags", 64'(exc), 64'({5'b00100, 5'b00000, 5'b00100, 5'b00010}));
      tick();
      chk("mac_drain_valid", 64'(out_valid), 64'd0);

      // ---------------- ACC burst of 4, sticky underflow on lane 2 ----------------
      beat(1, 1, 0, {16'h3E00, 16'h1400, 16'h4000, 16'h3E00},
                    {16'h3E00, 16'h1400, 16'h3E00, 16'h3E00},
                    {16'h4000, 16'h3E00, 16'h0000, 16'h0000});
      tick();
      chk("acc_b1_valid", 64'(out_valid), 64'd0);
      beat(1, 0, 0, {16'h3E00, 16'h3E00, 16'h4000, 16'h3E00},
                    {4{16'h3E00}}, {4{16'h7C00}});
      tick();
      chk("acc_b2_valid", 64'(out_valid), 64'd0);
      tick();
      chk("acc_b3_valid", 64'(out_valid), 64'd0);
      in_last = 1'b1;
      tick();
      chk("acc_b4_valid", 64'(out_valid), 64'd0);
      idle();
      tick();
      chk("acc_out_valid", 64'(out_valid), 64'd1);
      chk("acc_cout", c_out, {16'h4300, 16'h4200, 16'h4400, 16'h4200});
      chk("acc_flags", 64'(exc), 64'({5'b00000, 5'b00010, 5'b00000, 5'b00000}));
      tick();
      chk("acc_single_pulse", 64'(out_valid), 64'd0);

      // ---------------- new burst clears sticky flags ----------------
      beat(1, 1, 0, {4{16'h3E00}}, {4{16'h3E00}}, {4{16'h0000}});
      tick();
      beat(1, 0, 1, {4{16'h3E00}}, {4{16'h3E00}}, {4{16'h7C00}});
      tick();
      idle();
      tick();
      chk("acc2_cout", c_out, {4{16'h4000}});
      chk("acc2_flags", 64'(exc), 64'd0);

      // ---------------- single-beat burst (first & last) ----------------
      beat(1, 1, 1, {4{16'h4000}}, {4{16'h4000}}, {4{16'h3E00}});
      tick();
      idle();
      tick();
      chk("acc1b_valid", 64'(out_valid), 64'd1);
      chk("acc1b_cout", c_out, {4{16'h4280}});
      tick();

      // ---------------- backpressure scoreboard, 20 beats ----------------
      k = 0;
      got = 0;
      for (int c = 0; c < 80 && got < 20; c++) begin
         out_ready = !(c >= 4 && c <= 8);
         if (k < 20) begin
            v = 16'h3E00 + 16'(k);
            beat(0, 0, 0, {4{v}}, {4{16'h3E00}}, 64'd0);
         end else begin
            idle();
         end
         #1;
         if (c == 4) begin
            chk("bp_stall_valid", 64'(out_valid), 64'd1);
            chk("bp_stall_inready", 64'(in_ready), 64'd0);
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(16'h3E00 + 16'(k));
            k++;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("bp_unexpected_out", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("bp_cout", c_out, {4{e}});
               chk("bp_flags", 64'(exc), 64'd0);
            end
            got++;
         end
         tick();
      end
      chk("bp_received", 64'(got), 64'd20);
      chk("bp_pending", 64'(exp_q.size()), 64'd0);
      out_ready = 1'b1;
      idle();
      tick(); tick();

      // ---------------- reset mid-burst ----------------
      beat(0, 0, 0, {4{16'hFFFF}}, {4{16'h3E00}}, {4{16'h3E00}});
      tick();
      idle();
      tick();
      chk("pre_rst_flags", 64'(exc), 64'({4{5'b10000}}));
      tick();
      beat(1, 1, 0, {4{16'h3E00}}, {4{16'h3E00}}, {4{16'h4000}});
      tick();
      beat(1, 0, 0, {4{16'h3E00}}, {4{16'h3E00}}, {4{16'h0000}});
      rst_n = 1'b0;
      tick();
      chk("mrst_valid", 64'(out_valid), 64'd0);
      chk("mrst_cout", c_out, 64'd0);
      chk("mrst_flags", 64'(exc), 64'd0);
      rst_n = 1'b1;
      idle();
      tick();
      chk("mrst_inready", 64'(in_ready), 64'd1);
      tick();
      chk("mrst_discard", 64'(out_valid), 64'd0);

      // burst without first after reset accumulates onto zero
      beat(1, 0, 1, {4{16'h4000}}, {4{16'h3E00}}, {4{16'h7C00}});
      tick();
      idle();
      tick();
      chk("nofirst_cout", c_out, {4{16'h4000}});
      // fresh burst with first: no residue from earlier state
      beat(1, 1, 0, {4{16'h3E00}}, {4{16'h3E00}}, {4{16'h0000}});
      tick();
      in_first = 1'b0;
      tick();
      in_last = 1'b1;
      tick();
      idle();
      tick();
      chk("post_rst_valid", 64'(out_valid), 64'd1);
      chk("post_rst_cout", c_out, {4{16'h4100}});
      chk("post_rst_flags", 64'(exc), 64'd0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
